// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: EX-decoded op codes and FSM states.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic f_is_mul(input mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_MULTU);
  endfunction

  function automatic logic f_is_signed(input mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

  function automatic logic f_is_arith(input mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_MULTU) || (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned iterative datapath: one shift-add multiply or restoring-divide step per enabled cycle.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             i_load,
  input  logic             i_div,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // Multiply: {acc,q} shifts right, adding m whenever the multiplier LSB is set.
  assign w_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
  // Divide: {acc,q} shifts left; the partial remainder is kept only if it covers m.
  assign w_shl  = {r_acc, r_q[WIDTH-1]};
  assign w_diff = w_shl - {1'b0, r_m};

  always_comb begin
    w_acc_nxt = w_sum[WIDTH:1];
    w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
    if (i_div) begin
      w_acc_nxt = w_diff[WIDTH] ? w_shl[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_q_nxt   = {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
    end
  end

  always_ff @(posedge CLK) begin
    if (i_load) begin
      r_acc <= '0;
      r_q   <= i_a;
      r_m   <= i_b;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
    end
  end

  assign o_hi = r_acc;
  assign o_lo = r_q;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; signs are stripped on issue and
// restored in the FIX cycle, so the iterative core only ever sees magnitudes.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  mdu_state_e       r_state;
  mdu_op_e          r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  mdu_op_e            w_op;
  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_core_hi;
  logic [WIDTH-1:0]   w_core_lo;
  logic [2*WIDTH-1:0] w_fast_raw;
  logic [2*WIDTH-1:0] w_prod_raw;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_op     = mdu_op_e'(op);
  assign w_accept = start && !flush && (r_state == S_IDLE) && f_is_arith(w_op);
  assign w_a_neg  = f_is_signed(w_op) && rs_data[WIDTH-1];
  assign w_b_neg  = f_is_signed(w_op) && rt_data[WIDTH-1];
  assign w_a_mag  = f_neg_w(rs_data, w_a_neg);
  assign w_b_mag  = f_neg_w(rt_data, w_b_neg);

  mdu_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .CLK    (CLK),
    .i_load (w_accept),
    .i_div  (!f_is_mul(r_op)),
    .i_step (r_state == S_CALC),
    .i_a    (w_a_mag),
    .i_b    (w_b_mag),
    .o_hi   (w_core_hi),
    .o_lo   (w_core_lo)
  );

  if (FAST_MUL) begin : g_fast
    logic [2*WIDTH-1:0] r_fast;
    always_ff @(posedge CLK) begin
      if (w_accept) r_fast <= {{WIDTH{1'b0}}, w_a_mag} * {{WIDTH{1'b0}}, w_b_mag};
    end
    assign w_fast_raw = r_fast;
  end else begin : g_iter
    assign w_fast_raw = '0;
  end

  // Sign restoration; MIN/-1 wraps back to MIN on its own, and rt==0 leaves rem==|rs|.
  assign w_prod_raw = (FAST_MUL && f_is_mul(r_op)) ? w_fast_raw : {w_core_hi, w_core_lo};
  assign w_prod     = f_neg_2w(w_prod_raw, r_neg_q);
  assign w_quot     = r_zero ? '1 : f_neg_w(w_core_lo, r_neg_q);
  assign w_rem      = f_neg_w(w_core_hi, r_neg_r);
  assign w_res_hi   = f_is_mul(r_op) ? w_prod[2*WIDTH-1:WIDTH] : w_rem;
  assign w_res_lo   = f_is_mul(r_op) ? w_prod[WIDTH-1:0]       : w_quot;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_op       <= MDU_MULT;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_zero     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              case (w_op)
                MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                  r_op    <= w_op;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_zero  <= !f_is_mul(w_op) && (rt_data == '0);
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= (FAST_MUL && f_is_mul(w_op)) ? S_FIX : S_CALC;
                end
                MDU_MTHI: r_hi <= rs_data;
                MDU_MTLO: r_lo <= rs_data;
                default: ;
              endcase
            end
          end
          S_CALC: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
          end
          S_FIX: begin
            r_hi       <= w_res_hi;
            r_lo       <= w_res_lo;
            r_div_zero <= r_zero;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: iterative instance plus a FAST_MUL instance on shared inputs.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  logic        f_busy, f_done, f_dz;
  logic [31:0] f_hi, f_lo;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(32), .FAST_MUL(1'b0)) u_dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(32), .FAST_MUL(1'b1)) u_fast (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .flush(flush), .busy(f_busy), .done(f_done), .div_zero(f_dz), .hi(f_hi), .lo(f_lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one arithmetic op and wait (bounded) for done; reports latencies from the accept edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt, output int flat);
    @(negedge CLK);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 0; flat = 0;
    bcnt = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (busy) bcnt++;
      if (f_done && flat == 0) flat = k;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, bcnt, flat, seen;

  initial begin
    RST = 1'b0; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0; flush = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_dz", 32'(div_zero), 32'h0);
    @(negedge CLK) RST = 1'b1;

    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, lat, bcnt, flat);
    chk("mult_lat", lat, 33);
    chk("mult_busy_cycles", bcnt, 33);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("fast_mult_lat", flat, 1);
    chk("fast_mult_hi", f_hi, 32'hFFFF_FFFF);
    chk("fast_mult_lo", f_lo, 32'hFFFF_FFFA);
    @(posedge CLK); #1;
    chk("done_pulse", 32'(done), 32'h0);

    run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, lat, bcnt, flat);
    chk("multu_lat", lat, 33);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);
    chk("fast_multu_lat", flat, 1);
    chk("fast_multu_hi", f_hi, 32'h0000_0002);
    chk("fast_multu_lo", f_lo, 32'hFFFF_FFFA);

    run_op(MDU_MULT, 32'h8000_0000, 32'h8000_0000, lat, bcnt, flat);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0000_0000);

    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt, flat);
    chk("div_lat", lat, 33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_dz", 32'(div_zero), 32'h0);

    run_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, lat, bcnt, flat);
    chk("div_negdiv_lo", lo, 32'hFFFF_FFFD);
    chk("div_negdiv_hi", hi, 32'h0000_0001);

    run_op(MDU_DIVU, 32'd100, 32'd7, lat, bcnt, flat);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    run_op(MDU_DIVU, 32'd7, 32'd0, lat, bcnt, flat);
    chk("dz_lat", lat, 33);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd7);
    chk("dz_flag", 32'(div_zero), 32'h1);
    repeat (3) @(posedge CLK); #1;
    chk("dz_hold", 32'(div_zero), 32'h1);

    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, flat);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);
    chk("ovf_dz", 32'(div_zero), 32'h0);

    // MTHI, then a MULT that gets flushed while a stray MTLO is held on start.
    @(negedge CLK);
    start = 1'b1; op = MDU_MTHI; rs_data = 32'h1234;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", 32'(busy), 32'h0);
    chk("mthi_done", 32'(done), 32'h0);
    @(negedge CLK);
    start = 1'b1; op = MDU_MULT; rs_data = 32'd3; rt_data = 32'd4;
    @(posedge CLK); #1;
    op = MDU_MTLO; rs_data = 32'hDEAD;
    chk("flush_busy_on", 32'(busy), 32'h1);
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    start = 1'b0; flush = 1'b1;
    @(posedge CLK); #1;
    chk("flush_busy_off", 32'(busy), 32'h0);
    chk("flush_no_done", 32'(done), 32'h0);
    chk("flush_lo_ignored", lo, 32'h8000_0000);
    @(negedge CLK) flush = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (done) seen++;
    end
    chk("flush_never_done", seen, 0);
    chk("flush_hi_kept", hi, 32'h1234);

    // Asynchronous reset in the middle of a divide.
    @(negedge CLK);
    start = 1'b1; op = MDU_DIV; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    @(negedge CLK) RST = 1'b1;
    run_op(MDU_DIVU, 32'd9, 32'd3, lat, bcnt, flat);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_lo", lo, 32'd3);
    chk("post_rst_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
